// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//
// Drives a combinational function block through every input vector,
// captures its response into a truth-table register and compares that
// response against a reference table latched when the scan starts.
//
// Parameters:
//   N_IN    number of function inputs; the table is 2**N_IN bits wide
//   SETTLE  extra cycles each vector is held before q_in is sampled
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst        asynchronous active-high reset
//   start      scan request, accepted only while idle
//   expected   reference table, bit i = expected q for vector i
//   vec        function inputs (vec[3]=a ... vec[0]=d for N_IN=4)
//   q_in       function output, sampled at the end of each settle window
//   busy       high while a scan is in progress
//   done       one-cycle pulse when the scan completes
//   table_out  captured truth table, bit i = q for vector i
//   mismatch   captured table differed from the reference in some bit
//   first_bad  lowest mismatching vector index (0 when mismatch=0)
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2**N_IN-1:0]    expected,
    output logic [N_IN-1:0]       vec,
    input  logic                  q_in,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    table_out,
    output logic                  mismatch,
    output logic [N_IN-1:0]       first_bad
);

    localparam int TW    = 2**N_IN;
    // Counter needs at least one bit even when SETTLE=0.
    localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [N_IN-1:0]   vec_q,       vec_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [TW-1:0]     exp_q,       exp_d;
    logic [TW-1:0]     table_q,     table_d;
    logic              mismatch_q,  mismatch_d;
    logic [N_IN-1:0]   first_bad_q, first_bad_d;
    logic              done_q,      done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            table_q     <= '0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            table_q     <= table_d;
            mismatch_q  <= mismatch_d;
            first_bad_q <= first_bad_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        table_d     = table_q;
        mismatch_d  = mismatch_q;
        first_bad_d = first_bad_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Accepted even during the done cycle; the done pulse still
                // ends on this edge because done_d defaults to 0.
                if (start) begin
                    state_d     = RUN;
                    vec_d       = '0;
                    cnt_d       = '0;
                    exp_d       = expected;
                    table_d     = '0;
                    mismatch_d  = 1'b0;
                    first_bad_d = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Last edge of this vector's settle window: sample.
                    table_d[vec_q] = q_in;
                    if ((q_in != exp_q[vec_q]) && !mismatch_q) begin
                        mismatch_d  = 1'b1;
                        first_bad_d = vec_q;
                    end
                    cnt_d = '0;
                    if (vec_q == VEC_LAST) begin
                        state_d = IDLE;
                        vec_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                vec_d   = '0;
            end
        endcase
    end

    assign vec       = vec_q;
    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mismatch_q;
    assign first_bad = first_bad_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    logic        clk;
    logic        rst;

    // Instance 0: default parameters, function q = d (vec[0]).
    logic        start0;
    logic [15:0] expected0;
    logic [3:0]  vec0;
    logic        q_in0;
    logic        busy0;
    logic        done0;
    logic [15:0] table0;
    logic        mismatch0;
    logic [3:0]  first_bad0;

    // Instance 1: SETTLE=0, function q = parity of vec.
    logic        start1;
    logic [15:0] expected1;
    logic [3:0]  vec1;
    logic        q_in1;
    logic        busy1;
    logic        done1;
    logic [15:0] table1;
    logic        mismatch1;
    logic [3:0]  first_bad1;

    int checks = 0;
    int errors = 0;

    assign q_in0 = vec0[0];
    assign q_in1 = ^vec1;

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .expected(expected0),
        .vec(vec0), .q_in(q_in0), .busy(busy0), .done(done0),
        .table_out(table0), .mismatch(mismatch0), .first_bad(first_bad0)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1),
        .vec(vec1), .q_in(q_in1), .busy(busy1), .done(done1),
        .table_out(table1), .mismatch(mismatch1), .first_bad(first_bad1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full scan on instance 0 with cycle-by-cycle checks.
    // disturb: re-pulse start and zero expected while vector 5 is driven.
    // hold_end: raise start before the final sample edge and leave it high.
    task automatic run_scan0(input logic [15:0] ref_tab, input bit disturb, input bit hold_end,
                             input logic [15:0] want_tab, input logic want_mm,
                             input logic [3:0] want_fb);
        expected0 = ref_tab;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("busy_after_start", 32'(busy0), 32'd1);
        check("vec_after_start", 32'(vec0), 32'd0);
        check("table_cleared", 32'(table0), 32'd0);
        check("mismatch_cleared", 32'(mismatch0), 32'd0);
        for (int j = 1; j < 32; j++) begin
            if (disturb && j == 11) begin
                start0 = 1'b1;
                expected0 = 16'h0000;
            end
            if (disturb && j == 12) start0 = 1'b0;
            if (hold_end && j == 31) start0 = 1'b1;
            tick();
            check($sformatf("busy_c%0d", j), 32'(busy0), 32'd1);
            check($sformatf("vec_c%0d", j), 32'(vec0), 32'(j / 2));
            check($sformatf("done_early_c%0d", j), 32'(done0), 32'd0);
        end
        tick();
        check("done_pulse", 32'(done0), 32'd1);
        check("busy_end", 32'(busy0), 32'd0);
        check("vec_wrap", 32'(vec0), 32'd0);
        check("table_out", 32'(table0), 32'(want_tab));
        check("mismatch", 32'(mismatch0), 32'(want_mm));
        check("first_bad", 32'(first_bad0), 32'(want_fb));
        if (!hold_end) begin
            tick();
            check("done_one_cycle", 32'(done0), 32'd0);
            check("table_hold", 32'(table0), 32'(want_tab));
            check("mismatch_hold", 32'(mismatch0), 32'(want_mm));
            check("first_bad_hold", 32'(first_bad0), 32'(want_fb));
        end
        $display("scan0 ref=%h table=%h mismatch=%0d first_bad=%0d", ref_tab, table0, mismatch0, first_bad0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        expected0 = 16'h0;
        expected1 = 16'h0;
        #2;
        check("rst_vec", 32'(vec0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_table", 32'(table0), 32'd0);
        check("rst_mismatch", 32'(mismatch0), 32'd0);
        check("rst_first_bad", 32'(first_bad0), 32'd0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy0), 32'd0);

        // Scenario 1: matching reference.
        run_scan0(16'hAAAA, 1'b0, 1'b0, 16'hAAAA, 1'b0, 4'd0);
        // Scenario 2: bits 1 and 15 differ; first_bad must stay at 1.
        run_scan0(16'h2AA8, 1'b0, 1'b0, 16'hAAAA, 1'b1, 4'd1);

        // Scenario 3: SETTLE=0, parity function, 16-cycle scan.
        expected1 = 16'h6996;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("s0_busy_start", 32'(busy1), 32'd1);
        check("s0_vec_start", 32'(vec1), 32'd0);
        for (int j = 1; j < 16; j++) begin
            tick();
            check($sformatf("s0_busy_c%0d", j), 32'(busy1), 32'd1);
            check($sformatf("s0_vec_c%0d", j), 32'(vec1), 32'(j));
        end
        tick();
        check("s0_done", 32'(done1), 32'd1);
        check("s0_busy_end", 32'(busy1), 32'd0);
        check("s0_table", 32'(table1), 32'h6996);
        check("s0_mismatch", 32'(mismatch1), 32'd0);
        check("s0_first_bad", 32'(first_bad1), 32'd0);
        tick();
        check("s0_done_one_cycle", 32'(done1), 32'd0);
        $display("scan1 ref=6996 table=%h mismatch=%0d", table1, mismatch1);

        // Scenario 4: start re-pulse and expected change mid-scan are ignored.
        run_scan0(16'hAAAA, 1'b1, 1'b0, 16'hAAAA, 1'b0, 4'd0);

        // Scenario 5: reset while vector 7 is driven aborts the scan.
        expected0 = 16'hAAAA;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (14) tick();
        check("abort_vec7", 32'(vec0), 32'd7);
        rst = 1'b1;
        #1;
        check("abort_vec", 32'(vec0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_table", 32'(table0), 32'd0);
        check("abort_mismatch", 32'(mismatch0), 32'd0);
        check("abort_first_bad", 32'(first_bad0), 32'd0);
        #2 rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("abort_no_done_%0d", j), 32'(done0), 32'd0);
            check($sformatf("abort_idle_%0d", j), 32'(busy0), 32'd0);
        end
        $display("abort at vec 7 busy=%0d done=%0d", busy0, done0);
        run_scan0(16'hAAAA, 1'b0, 1'b0, 16'hAAAA, 1'b0, 4'd0);

        // Scenario 6: start held through the done cycle -> back-to-back scan.
        run_scan0(16'h2AA8, 1'b0, 1'b1, 16'hAAAA, 1'b1, 4'd1);
        expected0 = 16'hAAAA;
        tick();
        start0 = 1'b0;
        check("b2b_done_low", 32'(done0), 32'd0);
        check("b2b_busy", 32'(busy0), 32'd1);
        check("b2b_table_cleared", 32'(table0), 32'd0);
        check("b2b_mismatch_cleared", 32'(mismatch0), 32'd0);
        check("b2b_vec", 32'(vec0), 32'd0);
        begin
            int n;
            n = 0;
            while (!done0 && n < 100) begin
                tick();
                n++;
            end
            check("b2b_cycles_to_done", 32'(n), 32'd32);
        end
        check("b2b_table", 32'(table0), 32'hAAAA);
        check("b2b_mismatch", 32'(mismatch0), 32'd0);
        tick();
        check("b2b_done_one_cycle", 32'(done0), 32'd0);
        $display("back-to-back table=%h mismatch=%0d", table0, mismatch0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
